// File: rtl/bcd_count_animator_pkg.sv
// Shared types and elaboration helpers for the BCD count animator.
// Holds the FSM state encoding, the BCD digit type and the digit-count check function.
package bcd_anim_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t DIGIT_MAX = 4'd9;

  // Number of decimal digits needed to show the largest WIDTH-bit unsigned value.
  function automatic int min_digits(input int width);
    longint unsigned v;
    int              n;
    v = (64'd1 << width) - 64'd1;
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_count_animator_if.sv
// Load/display bus between the result register, the animator and the scan driver.
// The bypass signal only exists when BCD_ANIM_BYPASS_EN is defined.
interface bcd_count_animator_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  data_valid;
  logic [WIDTH-1:0]      data;
  logic                  signed_mode;
  logic [4*DIGITS-1:0]   bcd;
  logic                  neg;
  logic                  busy;
  logic                  done;
`ifdef BCD_ANIM_BYPASS_EN
  logic                  bypass;

  modport master (
    output data_valid, data, signed_mode, bypass,
    input  bcd, neg, busy, done
  );
  modport slave (
    input  data_valid, data, signed_mode, bypass,
    output bcd, neg, busy, done
  );
`else
  modport master (
    output data_valid, data, signed_mode,
    input  bcd, neg, busy, done
  );
  modport slave (
    input  data_valid, data, signed_mode,
    output bcd, neg, busy, done
  );
`endif
endinterface

// File: rtl/bcd_count_animator_digit.sv
// One BCD digit that counts up or down by one when enabled and its carry-in is set.
// With BCD_ANIM_BYPASS_EN the digit can also be loaded directly.
module bcd_updown_digit
  import bcd_anim_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       cin,
`ifdef BCD_ANIM_BYPASS_EN
  input  logic       load,
  input  bcd_digit_t load_val,
`endif
  output bcd_digit_t digit,
  output logic       cout
);

  // Ripple out: carry on 9->0 when counting up, borrow on 0->9 when counting down.
  assign cout = cin & (up ? (digit == DIGIT_MAX) : (digit == 4'd0));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= 4'd0;
`ifdef BCD_ANIM_BYPASS_EN
    end else if (load) begin
      digit <= load_val;
`endif
    end else if (en && cin) begin
      if (up) digit <= (digit == DIGIT_MAX) ? 4'd0 : digit + 4'd1;
      else    digit <= (digit == 4'd0) ? DIGIT_MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_count_animator.sv
// Animates an N-digit sign+magnitude BCD readout toward a new target, one step per tick.
// Define BCD_ANIM_BYPASS_EN to add an immediate-load bypass input.
module bcd_count_animator
  import bcd_anim_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DIGITS   = 5,
  parameter int RATE_DIV = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  bcd_count_animator_if.slave  bus
);

  localparam int                VW       = WIDTH + 1;
  localparam int                PRE_W    = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(RATE_DIV - 1);
  localparam logic signed [VW-1:0] V_ONE = VW'(1);

  if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
    $error("bcd_count_animator: DIGITS cannot show every WIDTH-bit magnitude");
  end
  if (RATE_DIV < 1) begin : g_bad_rate
    $error("bcd_count_animator: RATE_DIV must be at least 1");
  end

  state_t                 state;
  state_t                 state_nxt;
  logic                   done_q;
  logic                   done_nxt;
  logic                   busy;

  logic [PRE_W-1:0]       presc;
  logic signed [VW-1:0]   target_q;
  logic [WIDTH-1:0]       mag_q;
  logic                   neg_q;

  logic signed [VW-1:0]   t_load;
  logic signed [VW-1:0]   mag_ext;
  logic signed [VW-1:0]   v_ext;
  logic signed [VW-1:0]   v_step;
  logic                   tick;
  logic                   step;
  logic                   up;
  logic                   mag_inc;
  logic                   load_hit;
  logic                   arrive;
  logic                   bypass_load;

  logic [DIGITS:0]        carry;
  logic [4*DIGITS-1:0]    bcd_w;
  logic                   unused_ripple_out;

  // Target and displayed value are compared as WIDTH+1-bit signed numbers.
  assign t_load   = bus.signed_mode ? $signed({bus.data[WIDTH-1], bus.data})
                                    : $signed({1'b0, bus.data});
  assign mag_ext  = $signed({1'b0, mag_q});
  assign v_ext    = neg_q ? -mag_ext : mag_ext;
  assign load_hit = (t_load == v_ext);

  assign tick     = (presc == PRE_LAST);
  assign step     = (state == RUN) && tick && !bus.data_valid;
  assign up       = (target_q > v_ext);
  assign v_step   = up ? v_ext + V_ONE : v_ext - V_ONE;
  assign arrive   = (v_step == target_q);

  // Magnitude grows when moving away from zero, including the 0 -> -1 crossing.
  assign mag_inc  = up ? !neg_q : (neg_q || (mag_q == '0));

`ifdef BCD_ANIM_BYPASS_EN
  logic [WIDTH-1:0]    load_mag;
  logic [4*DIGITS-1:0] load_bcd;

  function automatic logic [4*DIGITS-1:0] to_bcd(input logic [WIDTH-1:0] bin);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
      end
      r = {r[4*DIGITS-2:0], bin[i]};
    end
    return r;
  endfunction

  assign bypass_load = bus.data_valid && bus.bypass;
  assign load_mag    = t_load[VW-1] ? WIDTH'(-t_load) : t_load[WIDTH-1:0];
  assign load_bcd    = to_bcd(load_mag);
`else
  assign bypass_load = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state; a load always wins over a step in the same cycle.
  // NOTE: defaults first so no path leaves a variable unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    if (bus.data_valid) begin
      if (load_hit || bypass_load) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end else begin
        state_nxt = RUN;
      end
    end else if (step && arrive) begin
      state_nxt = IDLE;
      done_nxt  = 1'b1;
    end
  end

  // FSM outputs.
  always_comb begin
    busy = (state == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= done_nxt;
  end

  // Target, prescaler and the sign+magnitude copy of the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= '0;
      presc    <= '0;
      mag_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      if (bus.data_valid) begin
        target_q <= t_load;
        presc    <= '0;
      end else if (state == RUN) begin
        presc <= tick ? '0 : presc + 1'b1;
      end

`ifdef BCD_ANIM_BYPASS_EN
      if (bypass_load) begin
        mag_q <= load_mag;
        neg_q <= t_load[VW-1];
      end else
`endif
      if (step) begin
        mag_q <= mag_inc ? mag_q + 1'b1 : mag_q - 1'b1;
        if (!up && !neg_q && (mag_q == '0))           neg_q <= 1'b1;
        else if (up && neg_q && (mag_q == WIDTH'(1))) neg_q <= 1'b0;
      end
    end
  end

  // Digit chain mirrors the magnitude; the ripple settles within the step cycle.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_updown_digit u_digit (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (step),
      .up       (mag_inc),
      .cin      (carry[i]),
`ifdef BCD_ANIM_BYPASS_EN
      .load     (bypass_load),
      .load_val (load_bcd[4*i +: 4]),
`endif
      .digit    (bcd_w[4*i +: 4]),
      .cout     (carry[i+1])
    );
  end

  assign unused_ripple_out = carry[DIGITS];

  assign bus.bcd  = bcd_w;
  assign bus.neg  = neg_q;
  assign bus.busy = busy;
  assign bus.done = done_q;

endmodule

// File: tb/tb_bcd_count_animator.sv
// Bench for bcd_count_animator: two instances (RATE_DIV 1 and 4) against an integer model.
// Honours BCD_ANIM_BYPASS_EN when the bundle is built with it.
module tb_bcd_count_animator;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic byp [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_count_animator_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus0 ();
  bcd_count_animator_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus1 ();

`ifdef BCD_ANIM_BYPASS_EN
  assign bus0.bypass = byp[0];
  assign bus1.bypass = byp[1];
`endif

  bcd_count_animator #(.WIDTH(WIDTH), .DIGITS(DIGITS), .RATE_DIV(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  bcd_count_animator #(.WIDTH(WIDTH), .DIGITS(DIGITS), .RATE_DIV(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  // Reference model: displayed value and target as plain integers.
  int m_v [2];
  int m_t [2];
  int m_pre [2];
  bit m_run [2];
  bit m_done [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] exp_bcd(input int v);
    logic [19:0] r;
    int m;
    m = (v < 0) ? -v : v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic model_step(input int k, input logic dv, input logic [15:0] d,
                            input logic sm, input logic bp);
    int rate;
    rate = (k == 0) ? 1 : 4;
    m_done[k] = 1'b0;
    if (dv) begin
      m_t[k]   = sm ? int'($signed(d)) : int'(d);
      m_pre[k] = 0;
      if (bp) m_v[k] = m_t[k];
      if (m_t[k] == m_v[k]) begin
        m_run[k]  = 1'b0;
        m_done[k] = 1'b1;
      end else begin
        m_run[k] = 1'b1;
      end
    end else if (m_run[k]) begin
      if (m_pre[k] == rate - 1) begin
        m_pre[k] = 0;
        m_v[k]   = m_v[k] + ((m_t[k] > m_v[k]) ? 1 : -1);
        if (m_v[k] == m_t[k]) begin
          m_run[k]  = 1'b0;
          m_done[k] = 1'b1;
        end
      end else begin
        m_pre[k]++;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_v[k] = 0; m_t[k] = 0; m_pre[k] = 0; m_run[k] = 1'b0; m_done[k] = 1'b0;
      end
    end else begin
      model_step(0, bus0.data_valid, bus0.data, bus0.signed_mode, byp[0]);
      model_step(1, bus1.data_valid, bus1.data, bus1.signed_mode, byp[1]);
    end
  end

  // Every cycle out of reset, both instances must match the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("bcd0",  32'(bus0.bcd),  32'(exp_bcd(m_v[0])));
      check("neg0",  32'(bus0.neg),  32'(m_v[0] < 0));
      check("busy0", 32'(bus0.busy), 32'(m_run[0]));
      check("done0", 32'(bus0.done), 32'(m_done[0]));
      check("bcd1",  32'(bus1.bcd),  32'(exp_bcd(m_v[1])));
      check("neg1",  32'(bus1.neg),  32'(m_v[1] < 0));
      check("busy1", 32'(bus1.busy), 32'(m_run[1]));
      check("done1", 32'(bus1.done), 32'(m_done[1]));
    end
  end

  function automatic logic busy_of(input int k);
    return (k == 0) ? bus0.busy : bus1.busy;
  endfunction

  task automatic set_in(input int k, input logic dv, input logic [15:0] d, input logic sm);
    if (k == 0) begin
      bus0.data_valid = dv; bus0.data = d; bus0.signed_mode = sm;
    end else begin
      bus1.data_valid = dv; bus1.data = d; bus1.signed_mode = sm;
    end
  endtask

  // Returns #1 after the load edge; the next negedge shows the state after that edge.
  task automatic load(input int k, input logic [15:0] d, input logic sm);
    @(posedge clk); #1;
    set_in(k, 1'b1, d, sm);
    @(posedge clk); #1;
    set_in(k, 1'b0, d, sm);
  endtask

  task automatic wait_idle(input int k, input int budget);
    int n;
    n = 0;
    while (busy_of(k) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy_of(k)), 32'd0);
  endtask

  task automatic run_count(input int k, input int window, output int busy_n, output int done_n);
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < window; i++) begin
      @(negedge clk);
      busy_n += (k == 0) ? int'(bus0.busy) : int'(bus1.busy);
      done_n += (k == 0) ? int'(bus0.done) : int'(bus1.done);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int busy_n, done_n, neg_at, first1, first2, n, x;
    logic [19:0] rec [4];
    logic [15:0] d;
    logic sm;
    int hold [2];

    byp[0] = 1'b0; byp[1] = 1'b0;
    set_in(0, 1'b0, 16'h0, 1'b0);
    set_in(1, 1'b0, 16'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_bcd",  32'(bus0.bcd),  32'd0);
    check("rst_busy", 32'(bus0.busy), 32'd0);
    check("rst_done", 32'(bus0.done), 32'd0);
    rst_n = 1'b1;

    // 1: reset while running
    load(0, 16'd40, 1'b0);
    repeat (5) @(negedge clk);
    check("t1_busy_before", 32'(bus0.busy), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t1_bcd",  32'(bus0.bcd),  32'd0);
    check("t1_neg",  32'(bus0.neg),  32'd0);
    check("t1_busy", 32'(bus0.busy), 32'd0);
    check("t1_done", 32'(bus0.done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 2: 0 -> 12
    load(0, 16'd12, 1'b0);
    run_count(0, 20, busy_n, done_n);
    check("t2_busy_cycles", 32'(busy_n), 32'd12);
    check("t2_done_pulses", 32'(done_n), 32'd1);
    check("t2_bcd", 32'(bus0.bcd), 32'h00012);

    // 3: 12 -> 5
    load(0, 16'd5, 1'b0);
    run_count(0, 20, busy_n, done_n);
    check("t3_busy_cycles", 32'(busy_n), 32'd7);
    check("t3_bcd", 32'(bus0.bcd), 32'h00005);
    check("t3_neg", 32'(bus0.neg), 32'd0);

    // 4: 2 -> -3 signed
    load(0, 16'd2, 1'b0);
    wait_idle(0, 50);
    load(0, 16'hFFFD, 1'b1);
    neg_at = -1;
    busy_n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus0.neg && neg_at < 0) neg_at = i;
      busy_n += int'(bus0.busy);
    end
    check("t4_neg_at", 32'(neg_at), 32'd3);
    check("t4_busy_cycles", 32'(busy_n), 32'd5);
    check("t4_bcd", 32'(bus0.bcd), 32'h00003);
    check("t4_neg", 32'(bus0.neg), 32'd1);

    // 5: ripple across 9999 -> 10000
    load(0, 16'd9998, 1'b0);
    wait_idle(0, 12000);
    check("t5_start", 32'(bus0.bcd), 32'h09998);
    load(0, 16'd10001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rec[i] = bus0.bcd;
    end
    check("t5_seq1", 32'(rec[1]), 32'h09999);
    check("t5_seq2", 32'(rec[2]), 32'h10000);
    check("t5_seq3", 32'(rec[3]), 32'h10001);

    // 6: retarget at V=20 while heading for 50
    pulse_reset();
    load(0, 16'd50, 1'b0);
    n = 0;
    while (bus0.bcd != 20'h00020 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_20", 32'(n < 200), 32'd1);
    set_in(0, 1'b1, 16'd10, 1'b0);
    @(posedge clk); #1;
    set_in(0, 1'b0, 16'd10, 1'b0);
    run_count(0, 30, busy_n, done_n);
    check("t6_busy_cycles", 32'(busy_n), 32'd10);
    check("t6_done_pulses", 32'(done_n), 32'd1);
    check("t6_bcd", 32'(bus0.bcd), 32'h00010);

    // 7: RATE_DIV=4 step timing
    load(1, 16'd2, 1'b0);
    first1 = -1;
    first2 = -1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (bus1.bcd == 20'h00001 && first1 < 0) first1 = i;
      if (bus1.bcd == 20'h00002 && first2 < 0) first2 = i;
    end
    check("t7_first_step", 32'(first1), 32'd4);
    check("t7_second_step", 32'(first2), 32'd8);

`ifdef BCD_ANIM_BYPASS_EN
    // 8: bypass load
    @(posedge clk); #1;
    byp[0] = 1'b1;
    set_in(0, 1'b1, 16'd65535, 1'b0);
    @(posedge clk); #1;
    byp[0] = 1'b0;
    set_in(0, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    check("t8_bcd",  32'(bus0.bcd),  32'h65535);
    check("t8_busy", 32'(bus0.busy), 32'd0);
    check("t8_done", 32'(bus0.done), 32'd1);
`endif

    // Random retargets, held strobes and boundary targets on both instances.
    hold[0] = 0;
    hold[1] = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        if (hold[k] > 0 || $urandom_range(0, 19) == 0) begin
          if (hold[k] > 0) hold[k]--;
          else if ($urandom_range(0, 7) == 0) hold[k] = int'($urandom_range(1, 4));
          sm = 1'($urandom_range(0, 1));
          case ($urandom_range(0, 9))
            0: d = 16'h0000;
            1: d = 16'hFFFF;
            2: d = 16'h8000;
            3: d = 16'h7FFF;
            default: begin
              x = int'($urandom_range(0, 80)) - 40;
              d = 16'(x);
            end
          endcase
`ifdef BCD_ANIM_BYPASS_EN
          byp[k] = ($urandom_range(0, 3) == 0);
`endif
          set_in(k, 1'b1, d, sm);
        end else begin
          byp[k] = 1'b0;
          set_in(k, 1'b0, 16'h0, 1'b0);
        end
      end
    end
    @(posedge clk); #1;
    byp[0] = 1'b0; byp[1] = 1'b0;
    set_in(0, 1'b0, 16'h0, 1'b0);
    set_in(1, 1'b0, 16'h0, 1'b0);
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
